uio_bus_arbiter: RTL and testbench

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

---
 rtl/uio_arb_pkg.sv | 23 ++
 rtl/uio_arb_burst_cnt.sv | 29 ++
 rtl/uio_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_uio_bus_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the two-requester UIO bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_e;

  localparam logic OWNER_0       = 1'b0;
  localparam logic OWNER_1       = 1'b1;
  localparam int   DEF_MAX_BURST = 8;
  localparam int   CNT_W         = 8;

  // Round-robin pick; only meaningful when at least one request is set.
  function automatic logic rr_pick(input logic a_req0, input logic a_req1,
                                   input logic a_last);
    if (a_req0 && a_req1) return ~a_last;
    return a_req1 ? OWNER_1 : OWNER_0;
  endfunction

endpackage

// File: rtl/uio_arb_burst_cnt.sv
// Saturating burst counter: clears on load, counts grant cycles, flags the
// last allowed cycle of a burst.
module uio_arb_burst_cnt
  import uio_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_inc,
  output logic o_term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear on load, otherwise count up and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (i_load)               r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Counter holds (cycles already granted - 1); terminal on the last one.
  assign o_term = (r_cnt >= TERM_VAL);

endmodule

// File: rtl/uio_bus_arbiter.sv
// Two-requester arbiter for a shared bidirectional UIO pad bus.
// Round-robin grant, mandatory one-cycle TURN gap between owners, pad
// readback tagged with its owner. Define UIO_ARB_TIMEOUT_EN to force an
// owner off the bus after MAX_BURST consecutive grant cycles.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] oe0,
  input  logic [7:0] oe1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       rowner
);

  arb_state_e r_state;
  logic       r_gnt0, r_gnt1, r_last;
  logic [7:0] r_rdata;
  logic       r_rvalid, r_rowner;

  logic w_own, w_owner, w_any, w_winner, w_term, w_timeout;

  assign w_own    = r_gnt0 | r_gnt1;
  assign w_owner  = r_gnt1 ? OWNER_1 : OWNER_0;
  assign w_any    = req0 | req1;
  assign w_winner = rr_pick(req0, req1, r_last);

  // Counter is held clear outside ownership, so each OWN entry starts at 0.
  uio_arb_burst_cnt #(.MAX_BURST(MAX_BURST)) u_burst_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (!w_own || !ena),
    .i_inc  (w_own),
    .o_term (w_term)
  );

`ifdef UIO_ARB_TIMEOUT_EN
  assign w_timeout = w_term;
`else
  logic w_unused_term;
  assign w_unused_term = w_term;
  assign w_timeout     = 1'b0;
`endif

  // Arbitration FSM with registered grants and last-served pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_last  <= OWNER_1;
    end else if (!ena) begin
      r_state <= ST_IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_any) begin
            r_state <= w_winner ? ST_OWN1 : ST_OWN0;
            r_gnt0  <= ~w_winner;
            r_gnt1  <= w_winner;
          end else begin
            r_state <= ST_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
          end
        end
        ST_OWN0: begin
          if (!req0 || w_timeout) begin
            r_state <= ST_TURN;
            r_gnt0  <= 1'b0;
            r_last  <= OWNER_0;
          end
        end
        ST_OWN1: begin
          if (!req1 || w_timeout) begin
            r_state <= ST_TURN;
            r_gnt1  <= 1'b0;
            r_last  <= OWNER_1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

  // Pad readback: capture uio_in on every owned cycle, tag with owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rowner <= OWNER_0;
    end else begin
      r_rvalid <= w_own;
      if (w_own) begin
        r_rdata  <= uio_in;
        r_rowner <= w_owner;
      end
    end
  end

  // Pad drive follows the registered grant; nothing drives outside OWN.
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (r_gnt0) begin
      uio_out = wdata0;
      uio_oe  = oe0;
    end else if (r_gnt1) begin
      uio_out = wdata1;
      uio_oe  = oe1;
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign rowner = r_rowner;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural owner/turn model.
module tb_uio_bus_arbiter;

  localparam int MB = 4;
`ifdef UIO_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0, oe0 = '0, oe1 = '0, uio_in = '0;
  logic       gnt0, gnt1, rvalid, rowner;
  logic [7:0] uio_out, uio_oe, rdata;

  int checks = 0;
  int errors = 0;

  // Model: owner (-1 = nobody, covers IDLE and TURN), last served, burst length.
  int         m_own, m_last, m_burst;
  logic [7:0] m_rdata;
  logic       m_rvalid, m_rowner;

  uio_bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .oe0(oe0), .oe1(oe1),
    .gnt0(gnt0), .gnt1(gnt1), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .rdata(rdata), .rvalid(rvalid), .rowner(rowner)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1; m_burst = 0;
    m_rdata = '0; m_rvalid = 1'b0; m_rowner = 1'b0;
  endtask

  // One rising edge of the reference behaviour, using the current inputs.
  task automatic model_edge();
    int w;
    if (m_own >= 0) begin
      m_rdata = uio_in; m_rvalid = 1'b1; m_rowner = (m_own == 1);
    end else begin
      m_rvalid = 1'b0;
    end
    if (!ena) begin
      m_own = -1; m_burst = 0;
    end else if (m_own >= 0) begin
      m_burst++;
      if (!(m_own == 0 ? req0 : req1) || (TO && m_burst >= MB)) begin
        m_last = m_own; m_own = -1;
      end
    end else begin
      if (req0 && req1) w = 1 - m_last;
      else if (req0)    w = 0;
      else if (req1)    w = 1;
      else              w = -1;
      m_own = w; m_burst = 0;
    end
  endtask

  task automatic check_model();
    chk1("m_gnt0", gnt0, m_own == 0);
    chk1("m_gnt1", gnt1, m_own == 1);
    chk8("m_uio_out", uio_out, m_own == 0 ? wdata0 : m_own == 1 ? wdata1 : 8'h00);
    chk8("m_uio_oe", uio_oe, m_own == 0 ? oe0 : m_own == 1 ? oe1 : 8'h00);
    chk8("m_rdata", rdata, m_rdata);
    chk1("m_rvalid", rvalid, m_rvalid);
    chk1("m_rowner", rowner, m_rowner);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int cnt0, cnt1;
    model_reset();

    // Reset state
    #3;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk8("rst_uio_oe", uio_oe, 8'h00);
    chk8("rst_rdata", rdata, 8'h00);
    chk1("rst_rvalid", rvalid, 1'b0);
    check_model();

    // First grant after release takes one full edge
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1; req0 = 1'b1; oe0 = 8'hFF; wdata0 = 8'hA5;
    #1;
    chk1("pre_edge_gnt0", gnt0, 1'b0);
    cycle();
    chk1("first_gnt0", gnt0, 1'b1);
    chk8("first_uio_out", uio_out, 8'hA5);
    chk8("first_uio_oe", uio_oe, 8'hFF);

    // Hand over to requester 1 through TURN, then read back the pad
    req0 = 1'b0; req1 = 1'b1; oe1 = 8'h0F; wdata1 = 8'h5A; uio_in = 8'h3C;
    cycle();
    chk1("turn_gnt0", gnt0, 1'b0);
    chk1("turn_gnt1", gnt1, 1'b0);
    chk8("turn_uio_oe", uio_oe, 8'h00);
    cycle();
    chk1("own1_gnt1", gnt1, 1'b1);
    chk8("own1_uio_oe", uio_oe, 8'h0F);
    cycle();
    chk8("rb_rdata", rdata, 8'h3C);
    chk1("rb_rvalid", rvalid, 1'b1);
    chk1("rb_rowner", rowner, 1'b1);

    // Asynchronous reset mid-burst, no clock edge involved
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_gnt1", gnt1, 1'b0);
    chk8("arst_uio_oe", uio_oe, 8'h00);
    chk1("arst_rvalid", rvalid, 1'b0);
    chk8("arst_rdata", rdata, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b1; req1 = 1'b0;

    // Serve 0 fully, re-grant 0, drop ena, then both requests -> 1 first
    cycle();
    req0 = 1'b0;
    cycle();
    cycle();
    req0 = 1'b1;
    cycle();
    chk1("ena_own0", gnt0, 1'b1);
    ena = 1'b0;
    cycle();
    chk1("ena_off_gnt0", gnt0, 1'b0);
    ena = 1'b1; req1 = 1'b1;
    cycle();
    chk1("ena_back_gnt1", gnt1, 1'b1);
    chk1("ena_back_gnt0", gnt0, 1'b0);

`ifdef UIO_ARB_TIMEOUT_EN
    // Both held: MB cycles each owner, single TURN between
    for (int k = 1; k < MB; k++) begin cycle(); chk1("to_own1", gnt1, 1'b1); end
    cycle();
    chk1("to_turn_a", gnt0 | gnt1, 1'b0);
    chk8("to_turn_a_oe", uio_oe, 8'h00);
    for (int k = 0; k < MB; k++) begin cycle(); chk1("to_own0", gnt0, 1'b1); end
    cycle();
    chk1("to_turn_b", gnt0 | gnt1, 1'b0);
    cycle();
    chk1("to_own1_again", gnt1, 1'b1);
`else
    // req0 holds the bus indefinitely while req1 waits
    req1 = 1'b0;
    cycle();
    cycle();
    req1 = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      cnt0 += int'(gnt0);
      cnt1 += int'(gnt1);
    end
    chk8("hold_gnt0_cycles", 8'(cnt0), 8'd100);
    chk8("hold_gnt1_cycles", 8'(cnt1), 8'd0);
    req0 = 1'b0;
    cycle();
    chk1("hold_turn", gnt0 | gnt1, 1'b0);
    cycle();
    chk1("hold_then_gnt1", gnt1, 1'b1);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 4) == 0) req0 = ~req0;
      if ($urandom_range(0, 4) == 0) req1 = ~req1;
      ena    = ($urandom_range(0, 19) != 0);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      oe0    = 8'($urandom); oe1    = 8'($urandom);
      uio_in = 8'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
